spi_slave_port: RTL and testbench
=================================

// Module: spi_slave_port
// PURPOSE
// - SPI slave (responder) with CPU register port; far end of the system SPI master link.
// - SPI mode 2 (CPOL=1, CPHA=0), MSB first, DATABITS-bit frames, multi-byte bursts per SS_n assertion.
// - All SPI pins are oversampled in the clk domain. Needs clk >= 8x SCLK, i.e. SCLK half-period >= 4 clk.
// - Gives the CPU single-byte rx/tx holding registers, sticky status flags and an irq.
// PARAMETERS
// DATABITS     8   frame width, 1..16
// SYNC_STAGES  2   synchronizer depth on SCLK/MOSI/SS_n, >= 2
// PORTS
// clk          in   1   system clock
// reset_n      in   1   async active-low reset
// SCLK         in   1   SPI clock from master, idles high
// MOSI         in   1   master-out data
// SS_n         in   1   slave select, active low
// MISO         out  1   slave-out data
// MISO_oe      out  1   MISO tri-state enable, high while synced SS_n is low
// spi_select   in   1   register-port chip select
// mem_addr     in   3   register address
// read_n       in   1   read strobe, active low
// write_n      in   1   write strobe, active low
// data_from_cpu in  16  write data
// data_to_cpu  out  16  read data, registered
// irq          out  1   registered interrupt
// BEHAVIOUR
// - Register map: 0 rxdata (r), 1 txdata (w), 2 status (r; any write clears ROE/TOE/UND),
//   3 control (r/w irq enables at the status bit positions), 4..7 read 0.
// - Status bits: [9] BUSY (frame active), [8] E=ROE|TOE|UND, [7] RRDY, [6] TRDY, [5] UND, [4] TOE, [3] ROE.
// - Register port: write takes effect on the clk edge where spi_select & ~write_n.
//   data_to_cpu updates 1 clk after spi_select & ~read_n. Reading addr 0 clears RRDY on that edge.
// - Reset values: MISO=1, MISO_oe=0, data_to_cpu=0, irq=0, TRDY=1, all other flags 0,
//   control=0, rx/tx holding regs=0.
// - SCLK, MOSI and SS_n each pass through SYNC_STAGES flops.
//   Edge detect on synced SCLK/SS_n runs with total latency SYNC_STAGES+1 clk.
// - SS_n fall (synced):
//   - tx_shift <= tx_holding if primed (primed<=0, TRDY<=1); else tx_shift <= all-ones and UND<=1.
//   - bitcnt <= 0; BUSY <= 1.
// - SCLK fall (sample): rx_shift <= {rx_shift, MOSI_sync}; bitcnt++.
//   - When bitcnt reaches DATABITS: rx_holding <= shifted value, RRDY <= 1, bitcnt <= 0.
//   - If RRDY was already 1 at that point: ROE <= 1 and rx_holding is still overwritten.
// - SCLK rise (drive): if bitcnt==0 and frame active, reload tx_shift from holding
//   (same primed/UND rule as SS_n fall); else tx_shift <= tx_shift << 1.
// - MISO = tx_shift[DATABITS-1] at all times.
// - txdata write: if TRDY, tx_holding <= data[DATABITS-1:0], primed <= 1, TRDY <= 0.
//   If ~TRDY, TOE <= 1 and holding is unchanged.
// - SS_n rise (synced) mid-frame: discard partial rx bits, no RRDY, bitcnt <= 0, BUSY <= 0.
//   A primed tx_holding stays primed.
// - Simultaneous events in the same clk:
//   - byte-complete and rxdata read: RRDY ends 1, ROE not set.
//   - reload and txdata write: the new write wins the holding register; TRDY ends 0.
//   - status write and flag set: the set wins.
// - irq <= |(status[9:3] & control[9:3]), registered, 1 clk latency.
// - reset_n asserted mid-frame aborts immediately; no partial byte is ever reported.
// STRUCTURE
// - Package spi_slave_pkg:
//   - address constants ADDR_RXDATA=0, ADDR_TXDATA=1, ADDR_STATUS=2, ADDR_CONTROL=3.
//   - status bit-index localparams.
// - Sub-module spi_slave_sync: SYNC_STAGES flop chain plus rise/fall detect;
//   instantiated for SCLK and SS_n (MOSI uses the chain only).
// - Top level holds the register port, holding regs, shift regs, bitcnt and flags.
// TESTING
// 1. Prime tx=0xA5, master sends 0x3C at SCLK=clk/8 -> MISO shifts 1,0,1,0,0,1,0,1;
//    rxdata=0x3C; RRDY=1, TRDY=1.
// 2. Two-byte burst, only 0x11 primed -> byte 2 on MISO is 0xFF, UND=1;
//    irq=1 one clk after UND when control[5]=1.
// 3. Master sends 0x01 then 0x02 with no CPU read -> rxdata=0x02, ROE=1;
//    status write clears ROE and E.
// 4. Two txdata writes before SS_n falls -> second write sets TOE=1; 0x55 (first) is transmitted.
// 5. SS_n released after 4 bits -> RRDY stays 0, BUSY=0;
//    next full frame 0x81 received correctly.
// 6. reset_n pulsed mid-frame -> MISO=1, MISO_oe=0, all flags at reset values;
//    the following frame is clean.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI slave port: register addresses, status bit
// positions and a helper that assembles the status word.
package spi_slave_pkg;

   localparam logic [2:0] ADDR_RXDATA  = 3'd0;
   localparam logic [2:0] ADDR_TXDATA  = 3'd1;
   localparam logic [2:0] ADDR_STATUS  = 3'd2;
   localparam logic [2:0] ADDR_CONTROL = 3'd3;

   localparam int ST_BUSY = 9;
   localparam int ST_E    = 8;
   localparam int ST_RRDY = 7;
   localparam int ST_TRDY = 6;
   localparam int ST_UND  = 5;
   localparam int ST_TOE  = 4;
   localparam int ST_ROE  = 3;

   // Only the irq-enable positions of the control register are writable.
   localparam logic [15:0] CTRL_MASK = 16'h03F8;

   function automatic logic [15:0] pack_status(
      input logic busy,
      input logic rrdy,
      input logic trdy,
      input logic und,
      input logic toe,
      input logic roe
   );
      logic [15:0] s;
      s          = 16'h0000;
      s[ST_BUSY] = busy;
      s[ST_E]    = roe | toe | und;
      s[ST_RRDY] = rrdy;
      s[ST_TRDY] = trdy;
      s[ST_UND]  = und;
      s[ST_TOE]  = toe;
      s[ST_ROE]  = roe;
      return s;
   endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Synchronizer chain for one SPI pin plus single-cycle rise/fall pulses
// derived from the synchronized level.
module spi_slave_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain_r;
   logic                   prev_r;

   // Synchronizer flops and the one-cycle-delayed copy used for edge detect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chain_r <= {SYNC_STAGES{RST_VAL}};
         prev_r  <= RST_VAL;
      end else begin
         chain_r <= {chain_r[SYNC_STAGES-2:0], din};
         prev_r  <= chain_r[SYNC_STAGES-1];
      end
   end

   assign dout = chain_r[SYNC_STAGES-1];
   assign rise = dout & ~prev_r;
   assign fall = ~dout & prev_r;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-2 slave with a CPU register port: oversampled SPI pins, rx/tx
// holding registers, sticky status flags and a registered interrupt.
module spi_slave_port
   import spi_slave_pkg::*;
#(
   parameter int DATABITS    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        SCLK,
   input  logic        MOSI,
   input  logic        SS_n,
   output logic        MISO,
   output logic        MISO_oe,
   input  logic        spi_select,
   input  logic [2:0]  mem_addr,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [15:0] data_from_cpu,
   output logic [15:0] data_to_cpu,
   output logic        irq
);

   localparam int            CW   = $clog2(DATABITS + 1);
   localparam logic [CW-1:0] LAST = CW'(DATABITS);

   logic sclk_s, sclk_rise_s, sclk_fall_s;
   logic ss_s, ss_rise_s, ss_fall_s;
   logic [SYNC_STAGES-1:0] mosi_chain_r;
   logic mosi_s;

   logic [DATABITS-1:0] tx_hold_r, tx_shift_r, rx_hold_r, rx_shift_r;
   logic [CW-1:0]       bitcnt_r;
   logic busy_r, primed_r, rrdy_r, trdy_r, und_r, toe_r, roe_r;
   logic [15:0] ctrl_r, data_to_cpu_r;
   logic irq_r;

   logic [DATABITS-1:0] tx_hold_nx_s, tx_shift_nx_s, rx_hold_nx_s, rx_shift_nx_s, rx_next_s;
   logic [CW-1:0]       bitcnt_nx_s;
   logic busy_nx_s, primed_nx_s, rrdy_nx_s, trdy_nx_s, und_nx_s, toe_nx_s, roe_nx_s;
   logic [15:0] ctrl_nx_s, data_to_cpu_nx_s, status_s;
   logic irq_nx_s;

   logic wr_s, rd_s, wr_tx_s, wr_st_s, wr_ctl_s, rd_rx_s;
   logic sample_s, drive_s, reload_s, take_s, done_s, tx_ok_s;

   spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (SCLK),
      .dout    (sclk_s),
      .rise    (sclk_rise_s),
      .fall    (sclk_fall_s)
   );

   spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (SS_n),
      .dout    (ss_s),
      .rise    (ss_rise_s),
      .fall    (ss_fall_s)
   );

   // MOSI runs through a chain of the same depth so it lines up with SCLK.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mosi_chain_r <= {SYNC_STAGES{1'b0}};
      end else begin
         mosi_chain_r <= {mosi_chain_r[SYNC_STAGES-2:0], MOSI};
      end
   end

   assign mosi_s = mosi_chain_r[SYNC_STAGES-1];

   assign wr_s     = spi_select & ~write_n;
   assign rd_s     = spi_select & ~read_n;
   assign wr_tx_s  = wr_s & (mem_addr == ADDR_TXDATA);
   assign wr_st_s  = wr_s & (mem_addr == ADDR_STATUS);
   assign wr_ctl_s = wr_s & (mem_addr == ADDR_CONTROL);
   assign rd_rx_s  = rd_s & (mem_addr == ADDR_RXDATA);

   assign status_s = pack_status(busy_r, rrdy_r, trdy_r, und_r, toe_r, roe_r);

   // SCLK edges only count inside a frame; SS_n release takes precedence.
   assign sample_s  = sclk_fall_s & busy_r & ~ss_rise_s;
   assign drive_s   = sclk_rise_s & busy_r & ~ss_rise_s;
   assign reload_s  = ss_fall_s | (drive_s & (bitcnt_r == {CW{1'b0}}));
   assign take_s    = reload_s & primed_r;
   assign rx_next_s = DATABITS'({rx_shift_r, mosi_s});
   assign done_s    = sample_s & ((bitcnt_r + CW'(1)) == LAST);
   assign tx_ok_s   = wr_tx_s & (trdy_r | take_s);

   // Next-state for frame tracking, shift/holding registers and flags.
   always_comb begin
      bitcnt_nx_s   = bitcnt_r;
      busy_nx_s     = busy_r;
      tx_shift_nx_s = tx_shift_r;
      tx_hold_nx_s  = tx_hold_r;
      primed_nx_s   = primed_r;
      trdy_nx_s     = trdy_r;
      rx_shift_nx_s = rx_shift_r;
      rx_hold_nx_s  = rx_hold_r;
      rrdy_nx_s     = rrdy_r;
      und_nx_s      = und_r;
      toe_nx_s      = toe_r;
      roe_nx_s      = roe_r;
      ctrl_nx_s     = ctrl_r;

      if (ss_fall_s) begin
         busy_nx_s     = 1'b1;
         bitcnt_nx_s   = {CW{1'b0}};
         rx_shift_nx_s = {DATABITS{1'b0}};
      end else if (ss_rise_s) begin
         busy_nx_s     = 1'b0;
         bitcnt_nx_s   = {CW{1'b0}};
         rx_shift_nx_s = {DATABITS{1'b0}};
      end else if (sample_s) begin
         if (done_s) begin
            bitcnt_nx_s   = {CW{1'b0}};
            rx_shift_nx_s = {DATABITS{1'b0}};
         end else begin
            bitcnt_nx_s   = bitcnt_r + CW'(1);
            rx_shift_nx_s = rx_next_s;
         end
      end else begin
         bitcnt_nx_s = bitcnt_r;
      end

      if (reload_s) begin
         tx_shift_nx_s = primed_r ? tx_hold_r : {DATABITS{1'b1}};
      end else if (drive_s) begin
         tx_shift_nx_s = tx_shift_r << 1;
      end else begin
         tx_shift_nx_s = tx_shift_r;
      end

      // A write landing on the same cycle as a reload refills the holding reg.
      if (tx_ok_s) begin
         tx_hold_nx_s = data_from_cpu[DATABITS-1:0];
         primed_nx_s  = 1'b1;
         trdy_nx_s    = 1'b0;
      end else if (take_s) begin
         primed_nx_s  = 1'b0;
         trdy_nx_s    = 1'b1;
      end else begin
         primed_nx_s  = primed_r;
      end

      if (done_s) begin
         rx_hold_nx_s = rx_next_s;
         rrdy_nx_s    = 1'b1;
      end else if (rd_rx_s) begin
         rrdy_nx_s    = 1'b0;
      end else begin
         rrdy_nx_s    = rrdy_r;
      end

      if (reload_s & ~primed_r) begin
         und_nx_s = 1'b1;
      end else if (wr_st_s) begin
         und_nx_s = 1'b0;
      end else begin
         und_nx_s = und_r;
      end

      if (wr_tx_s & ~tx_ok_s) begin
         toe_nx_s = 1'b1;
      end else if (wr_st_s) begin
         toe_nx_s = 1'b0;
      end else begin
         toe_nx_s = toe_r;
      end

      if (done_s & rrdy_r & ~rd_rx_s) begin
         roe_nx_s = 1'b1;
      end else if (wr_st_s) begin
         roe_nx_s = 1'b0;
      end else begin
         roe_nx_s = roe_r;
      end

      if (wr_ctl_s) begin
         ctrl_nx_s = data_from_cpu & CTRL_MASK;
      end else begin
         ctrl_nx_s = ctrl_r;
      end
   end

   // Register read mux; the read bus holds its value between reads.
   always_comb begin
      data_to_cpu_nx_s = data_to_cpu_r;
      if (rd_s) begin
         case (mem_addr)
            ADDR_RXDATA:  data_to_cpu_nx_s = 16'(rx_hold_r);
            ADDR_STATUS:  data_to_cpu_nx_s = status_s;
            ADDR_CONTROL: data_to_cpu_nx_s = ctrl_r;
            default:      data_to_cpu_nx_s = 16'h0000;
         endcase
      end else begin
         data_to_cpu_nx_s = data_to_cpu_r;
      end
      irq_nx_s = |(status_s[ST_BUSY:ST_ROE] & ctrl_r[ST_BUSY:ST_ROE]);
   end

   // State registers; reset aborts any frame in progress.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bitcnt_r      <= {CW{1'b0}};
         busy_r        <= 1'b0;
         tx_shift_r    <= {DATABITS{1'b1}};
         tx_hold_r     <= {DATABITS{1'b0}};
         primed_r      <= 1'b0;
         trdy_r        <= 1'b1;
         rx_shift_r    <= {DATABITS{1'b0}};
         rx_hold_r     <= {DATABITS{1'b0}};
         rrdy_r        <= 1'b0;
         und_r         <= 1'b0;
         toe_r         <= 1'b0;
         roe_r         <= 1'b0;
         ctrl_r        <= 16'h0000;
         data_to_cpu_r <= 16'h0000;
         irq_r         <= 1'b0;
      end else begin
         bitcnt_r      <= bitcnt_nx_s;
         busy_r        <= busy_nx_s;
         tx_shift_r    <= tx_shift_nx_s;
         tx_hold_r     <= tx_hold_nx_s;
         primed_r      <= primed_nx_s;
         trdy_r        <= trdy_nx_s;
         rx_shift_r    <= rx_shift_nx_s;
         rx_hold_r     <= rx_hold_nx_s;
         rrdy_r        <= rrdy_nx_s;
         und_r         <= und_nx_s;
         toe_r         <= toe_nx_s;
         roe_r         <= roe_nx_s;
         ctrl_r        <= ctrl_nx_s;
         data_to_cpu_r <= data_to_cpu_nx_s;
         irq_r         <= irq_nx_s;
      end
   end

   assign MISO        = tx_shift_r[DATABITS-1];
   assign MISO_oe     = ~ss_s;
   assign data_to_cpu = data_to_cpu_r;
   assign irq         = irq_r;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: an SPI master model at SCLK = clk/8 and
// a CPU register-port driver, checked against scoreboard queues.
module tb_spi_slave_port;

   logic        clk = 1'b0;
   logic        reset_n, SCLK, MOSI, SS_n, MISO, MISO_oe;
   logic        spi_select, read_n, write_n, irq;
   logic [2:0]  mem_addr;
   logic [15:0] data_from_cpu, data_to_cpu;

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_miso_q[$];
   logic [7:0] exp_rx_q[$];

   always #5 clk = ~clk;

   spi_slave_port #(.DATABITS(8), .SYNC_STAGES(2)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .SCLK          (SCLK),
      .MOSI          (MOSI),
      .SS_n          (SS_n),
      .MISO          (MISO),
      .MISO_oe       (MISO_oe),
      .spi_select    (spi_select),
      .mem_addr      (mem_addr),
      .read_n        (read_n),
      .write_n       (write_n),
      .data_from_cpu (data_from_cpu),
      .data_to_cpu   (data_to_cpu),
      .irq           (irq)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
      mem_addr = a; data_from_cpu = d; spi_select = 1'b1; write_n = 1'b0;
      @(negedge clk);
      spi_select = 1'b0; write_n = 1'b1;
   endtask

   task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
      mem_addr = a; spi_select = 1'b1; read_n = 1'b0;
      @(negedge clk);
      spi_select = 1'b0; read_n = 1'b1;
      d = data_to_cpu;
   endtask

   task automatic check_read(input string tag, input logic [2:0] a, input logic [15:0] exp);
      logic [15:0] d;
      cpu_read(a, d);
      check(tag, d, exp);
   endtask

   task automatic read_rx(input string tag);
      logic [15:0] d;
      cpu_read(3'd0, d);
      if (exp_rx_q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s: observed %h expected <no rx byte queued>", tag, d);
      end else begin
         check(tag, d, {8'h00, exp_rx_q.pop_front()});
      end
   endtask

   task automatic ss_begin(input string tag);
      SS_n = 1'b0;
      wclk(6);
      check(tag, MISO_oe, 1'b1);
   endtask

   task automatic ss_end(input string tag);
      wclk(4);
      SS_n = 1'b1;
      wclk(6);
      check(tag, MISO_oe, 1'b0);
   endtask

   // Master: drives MOSI while SCLK is high, samples MISO just before each fall.
   task automatic spi_bits(input string tag, input int nbits, input logic [7:0] mbyte);
      logic [7:0] cap;
      cap = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         MOSI = mbyte[7-i];
         wclk(4);
         cap = {cap[6:0], MISO};
         SCLK = 1'b0;
         wclk(4);
         SCLK = 1'b1;
      end
      if (nbits == 8) begin
         if (exp_miso_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed %h expected <no miso byte queued>", tag, cap);
         end else begin
            check(tag, {8'h00, cap}, {8'h00, exp_miso_q.pop_front()});
         end
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0; SCLK = 1'b1; MOSI = 1'b0; SS_n = 1'b1;
      spi_select = 1'b0; read_n = 1'b1; write_n = 1'b1;
      mem_addr = 3'd0; data_from_cpu = 16'h0000;
      wclk(3);
      check("rst miso", MISO, 1'b1);
      check("rst oe", MISO_oe, 1'b0);
      check("rst dout", data_to_cpu, 16'h0000);
      check("rst irq", irq, 1'b0);
      reset_n = 1'b1;
      wclk(2);
      check_read("rst status", 3'd2, 16'h0040);
      check_read("rst control", 3'd3, 16'h0000);
      check_read("addr5 zero", 3'd5, 16'h0000);

      // 1: primed A5 out, 3C in; trailing SCLK rise reloads unprimed -> UND
      cpu_write(3'd1, 16'h00A5);
      exp_miso_q.push_back(8'hA5);
      check_read("t1 primed status", 3'd2, 16'h0000);
      ss_begin("t1 oe on");
      exp_rx_q.push_back(8'h3C);
      spi_bits("t1 miso", 8, 8'h3C);
      ss_end("t1 oe off");
      check_read("t1 status", 3'd2, 16'h01E0);
      read_rx("t1 rxdata");
      cpu_write(3'd2, 16'h0000);
      check_read("t1 cleared", 3'd2, 16'h0040);

      // 2: two-byte burst with one primed byte -> FF underrun, irq on UND
      cpu_write(3'd3, 16'h0020);
      cpu_write(3'd1, 16'h0011);
      exp_miso_q.push_back(8'h11);
      exp_miso_q.push_back(8'hFF);
      check("t2 irq before", irq, 1'b0);
      ss_begin("t2 oe on");
      spi_bits("t2 miso b1", 8, 8'h12);
      spi_bits("t2 miso b2", 8, 8'h34);
      ss_end("t2 oe off");
      check("t2 irq und", irq, 1'b1);
      check_read("t2 status", 3'd2, 16'h01E8);
      exp_rx_q.push_back(8'h34);
      read_rx("t2 rxdata");
      cpu_write(3'd2, 16'h0000);
      wclk(2);
      check("t2 irq cleared", irq, 1'b0);
      cpu_write(3'd3, 16'h0000);

      // 3: two frames without a read -> ROE; irq one clk after enable
      exp_miso_q.push_back(8'hFF);
      exp_miso_q.push_back(8'hFF);
      ss_begin("t3 oe on a");
      spi_bits("t3 miso a", 8, 8'h01);
      ss_end("t3 oe off a");
      ss_begin("t3 oe on b");
      spi_bits("t3 miso b", 8, 8'h02);
      ss_end("t3 oe off b");
      check_read("t3 status", 3'd2, 16'h01E8);
      cpu_write(3'd3, 16'h0008);
      check("t3 irq same clk", irq, 1'b0);
      wclk(1);
      check("t3 irq next clk", irq, 1'b1);
      cpu_write(3'd2, 16'h0000);
      wclk(2);
      check("t3 irq after clear", irq, 1'b0);
      check_read("t3 status cleared", 3'd2, 16'h00C0);
      exp_rx_q.push_back(8'h02);
      read_rx("t3 rxdata");
      cpu_write(3'd3, 16'h0000);

      // 4: second txdata write overflows; first value goes out
      cpu_write(3'd1, 16'h0055);
      cpu_write(3'd1, 16'h00AA);
      check_read("t4 toe status", 3'd2, 16'h0110);
      exp_miso_q.push_back(8'h55);
      ss_begin("t4 oe on");
      exp_rx_q.push_back(8'hC3);
      spi_bits("t4 miso", 8, 8'hC3);
      ss_end("t4 oe off");
      check_read("t4 status", 3'd2, 16'h01F0);
      read_rx("t4 rxdata");
      cpu_write(3'd2, 16'h0000);
      check_read("t4 cleared", 3'd2, 16'h0040);

      // 5: frame aborted after 4 bits, then a clean frame
      ss_begin("t5 oe on a");
      spi_bits("t5 partial", 4, 8'hA0);
      check_read("t5 busy status", 3'd2, 16'h0360);
      ss_end("t5 oe off a");
      check_read("t5 abort status", 3'd2, 16'h0160);
      cpu_write(3'd2, 16'h0000);
      exp_miso_q.push_back(8'hFF);
      ss_begin("t5 oe on b");
      exp_rx_q.push_back(8'h81);
      spi_bits("t5 miso", 8, 8'h81);
      ss_end("t5 oe off b");
      check_read("t5 status", 3'd2, 16'h01E0);
      read_rx("t5 rxdata");
      cpu_write(3'd2, 16'h0000);

      // 6: reset mid-frame, then a clean frame
      cpu_write(3'd1, 16'h005A);
      ss_begin("t6 oe on a");
      spi_bits("t6 partial", 4, 8'hF0);
      reset_n = 1'b0;
      #1;
      check("t6 rst miso", MISO, 1'b1);
      check("t6 rst oe", MISO_oe, 1'b0);
      check("t6 rst irq", irq, 1'b0);
      check("t6 rst dout", data_to_cpu, 16'h0000);
      SS_n = 1'b1;
      wclk(3);
      reset_n = 1'b1;
      wclk(3);
      check_read("t6 status", 3'd2, 16'h0040);
      check_read("t6 control", 3'd3, 16'h0000);
      check_read("t6 rxdata zero", 3'd0, 16'h0000);
      cpu_write(3'd1, 16'h0096);
      exp_miso_q.push_back(8'h96);
      ss_begin("t6 oe on b");
      exp_rx_q.push_back(8'h69);
      spi_bits("t6 miso", 8, 8'h69);
      ss_end("t6 oe off b");
      check_read("t6 frame status", 3'd2, 16'h01E0);
      read_rx("t6 rxdata");

      check("sb miso drained", 16'(exp_miso_q.size()), 16'h0000);
      check("sb rx drained", 16'(exp_rx_q.size()), 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
